// File: rtl/row_line_fifo_pkg.sv
// Shared constants and sizing helpers for the row line buffer.
package row_line_fifo_pkg;

   localparam int unsigned DataWDef   = 8;
   localparam int unsigned DepthDef   = 1920;
   localparam int unsigned MaxRowTarx = DepthDef;

   function automatic int unsigned addr_w(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned cnt_w(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/row_line_fifo_if.sv
// Write and read handshake bundle of the row line buffer.
interface row_line_fifo_if
   import row_line_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = DataWDef
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/row_line_fifo_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port, no storage reset.
module row_line_fifo_sdp_ram
   import row_line_fifo_pkg::*;
#(
   parameter int unsigned Width = 9,
   parameter int unsigned Depth = 4,
   parameter int unsigned AddrW = addr_w(Depth)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AddrW-1:0] waddr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             re_i,
   input  logic [AddrW-1:0] raddr_i,
   output logic [Width-1:0] rdata_o
);
   logic [Width-1:0] mem [Depth];

   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem[raddr_i];
   end
endmodule

// File: rtl/row_line_fifo.sv
// Row buffer between the horizontal and vertical FIR stages: RAM FIFO with a
// two-entry first-word-fall-through output stage, fill level and sticky error flags.
module row_line_fifo
   import row_line_fifo_pkg::*;
#(
   parameter int unsigned DATA_W  = DataWDef,
   parameter int unsigned DEPTH   = DepthDef,
   localparam int unsigned PTR_W = addr_w(DEPTH),
   localparam int unsigned CNT_W = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   row_line_fifo_if.slave   bus,
   output logic [CNT_W-1:0] level,
   input  logic [CNT_W-1:0] afull_th,
   input  logic [CNT_W-1:0] aempty_th,
   output logic             almost_full,
   output logic             almost_empty,
   output logic             ovf_err,
   output logic             unf_err
);
   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } row_word_t;

   localparam logic [CNT_W-1:0] Full    = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PtrLast = PTR_W'(DEPTH - 1);

   logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CNT_W-1:0] level_q, level_d, ram_cnt;
   logic [1:0]       stg_cnt_q, stg_cnt_d, stg_kept;
   row_word_t        stg_q [2];
   row_word_t        stg_d [2];
   row_word_t        wr_word, rd_word;
   logic             rd_pend_q, rd_pend_d;
   logic             in_ready_q, in_ready_d, afull_q, afull_d, aempty_q, aempty_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             accept, pop, rd_en, out_valid;

   assign out_valid = (stg_cnt_q != 2'd0);

   always_comb begin
      accept  = bus.in_valid & in_ready_q & ~flush;
      pop     = out_valid & bus.out_ready & ~flush;
      // Words still in RAM: total minus output stage minus the read in flight.
      ram_cnt  = level_q - CNT_W'(stg_cnt_q) - CNT_W'(rd_pend_q);
      stg_kept = stg_cnt_q - {1'b0, pop};
      rd_en    = ~flush & (ram_cnt != '0) & ((stg_kept + {1'b0, rd_pend_q}) < 2'd2);
      wr_word  = '{last: bus.in_last, data: bus.in_data};

      wptr_d = wptr_q;
      if (accept) wptr_d = (wptr_q == PtrLast) ? '0 : wptr_q + 1'b1;
      rptr_d = rptr_q;
      if (rd_en) rptr_d = (rptr_q == PtrLast) ? '0 : rptr_q + 1'b1;

      stg_d = stg_q;
      if (pop) stg_d[0] = stg_q[1];
      if (rd_pend_q) stg_d[stg_kept[0]] = rd_word;
      stg_cnt_d = stg_kept + {1'b0, rd_pend_q};
      rd_pend_d = rd_en;

      level_d = level_q + CNT_W'(accept) - CNT_W'(pop);
      ovf_d   = ovf_q | (bus.in_valid & ~in_ready_q & (level_q == Full) & ~flush);
      unf_d   = unf_q | (bus.out_ready & ~out_valid & (level_q != '0) & ~flush);

      if (flush) begin
         wptr_d    = '0;
         rptr_d    = '0;
         level_d   = '0;
         stg_cnt_d = 2'd0;
         rd_pend_d = 1'b0;
      end

      in_ready_d = (level_d != Full);
      afull_d    = ~flush & (level_d >= afull_th);
      aempty_d   = flush | (level_d <= aempty_th);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         stg_cnt_q  <= 2'd0;
         rd_pend_q  <= 1'b0;
         in_ready_q <= 1'b1;
         afull_q    <= 1'b0;
         aempty_q   <= 1'b1;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         level_q    <= level_d;
         stg_cnt_q  <= stg_cnt_d;
         rd_pend_q  <= rd_pend_d;
         in_ready_q <= in_ready_d;
         afull_q    <= afull_d;
         aempty_q   <= aempty_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
      end
   end

   // Stage payload is only meaningful under stg_cnt_q, so it needs no reset.
   always_ff @(posedge clk) begin
      stg_q <= stg_d;
   end

   row_line_fifo_sdp_ram #(
      .Width (DATA_W + 1),
      .Depth (DEPTH),
      .AddrW (PTR_W)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (accept),
      .waddr_i (wptr_q),
      .wdata_i (wr_word),
      .re_i    (rd_en),
      .raddr_i (rptr_q),
      .rdata_o (rd_word)
   );

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = stg_q[0].data;
   assign bus.out_last  = stg_q[0].last;
   assign level         = level_q;
   assign almost_full   = afull_q;
   assign almost_empty  = aempty_q;
   assign ovf_err       = ovf_q;
   assign unf_err       = unf_q;
endmodule

// File: tb/tb_row_line_fifo.sv
// Randomized scoreboard bench for row_line_fifo at DEPTH=5.
module tb_row_line_fifo;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 5;
   localparam int unsigned CW    = $clog2(DEPTH + 1);

   typedef struct {
      logic [DW:0] w;
      int          t;
   } ent_t;

   logic          clk, rst, flush;
   logic [CW-1:0] level, afull_th, aempty_th;
   logic          almost_full, almost_empty, ovf_err, unf_err;

   row_line_fifo_if #(.DATA_W(DW)) bus ();

   row_line_fifo #(
      .DATA_W (DW),
      .DEPTH  (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .bus          (bus),
      .level        (level),
      .afull_th     (afull_th),
      .aempty_th    (aempty_th),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .ovf_err      (ovf_err),
      .unf_err      (unf_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ent_t        q[$];
   int          cyc = 0;
   bit          started = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;
   bit          exp_ovf = 1'b0;
   bit          exp_unf = 1'b0;
   bit          stall_prev = 1'b0;
   logic [DW:0] data_prev;
   bit          pend = 1'b0;
   int          word_n = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, got, exp);
      end
   endtask

   // Stimulus side: every accepted word goes into the expected queue with its accept edge.
   initial begin
      forever begin
         @(posedge clk);
         started = 1'b1;
         cyc++;
         if (!rst && !flush && bus.in_valid && bus.in_ready)
            q.push_back('{w: {bus.in_last, bus.in_data}, t: cyc});
      end
   end

   // Monitor: checks state after the last edge, then models the coming edge.
   initial begin
      bit vis;
      forever begin
         @(negedge clk);
         if (started) begin
            // A word becomes visible two edges after acceptance, once it is at the head.
            vis = (q.size() > 0) && (q[0].t + 2 <= cyc);
            chk("level", 32'(level), 32'(q.size()));
            chk("in_ready", 32'(bus.in_ready), 32'(q.size() != DEPTH));
            chk("out_valid", 32'(bus.out_valid), 32'(vis));
            if (vis && bus.out_valid) chk("out_word", 32'({bus.out_last, bus.out_data}), 32'(q[0].w));
            if (stall_prev) begin
               chk("stall_valid", 32'(bus.out_valid), 32'd1);
               chk("stall_word", 32'({bus.out_last, bus.out_data}), 32'(data_prev));
            end
            chk("almost_full", 32'(almost_full), 32'(q.size() >= int'(afull_th)));
            chk("almost_empty", 32'(almost_empty), 32'(q.size() <= int'(aempty_th)));
            chk("ovf_err", 32'(ovf_err), 32'(exp_ovf));
            chk("unf_err", 32'(unf_err), 32'(exp_unf));

            stall_prev = bus.out_valid && !bus.out_ready && !rst && !flush;
            data_prev  = {bus.out_last, bus.out_data};
            if (rst) begin
               q.delete();
               exp_ovf = 1'b0;
               exp_unf = 1'b0;
            end else if (flush) begin
               q.delete();
            end else begin
               if (bus.in_valid && q.size() == DEPTH) exp_ovf = 1'b1;
               if (bus.out_ready && !vis && q.size() != 0) exp_unf = 1'b1;
               if (vis && bus.out_ready) void'(q.pop_front());
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Percent chances: pv offer a word, pr consumer ready, pf flush.
   task automatic run(input int cycles, input int pv, input int pr, input int pf);
      bit acc;
      for (int c = 0; c < cycles; c++) begin
         if (!pend && $urandom_range(99) < pv) begin
            pend        = 1'b1;
            bus.in_data = DW'(word_n);
            bus.in_last = (word_n % 7 == 6);
         end
         bus.in_valid  = pend;
         bus.out_ready = ($urandom_range(99) < pr);
         flush         = ($urandom_range(99) < pf);
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready && !flush;
         step();
         if (acc) begin
            pend = 1'b0;
            word_n++;
         end
      end
      bus.in_valid = 1'b0;
      flush        = 1'b0;
   endtask

   initial begin
      rst           = 1'b1;
      flush         = 1'b0;
      afull_th      = CW'(4);
      aempty_th     = CW'(1);
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();

      // Single word latency, then pop.
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h11;
      step();
      bus.in_valid = 1'b0;
      repeat (3) step();
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      step();

      // Fill to full, overflow attempt, drain; repeated across the pointer wrap.
      for (int r = 0; r < 3; r++) begin
         for (int i = 1; i <= 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = DW'(i + 16 * r);
            bus.in_last  = (i == 5);
            step();
         end
         bus.in_data = 8'hEE;
         step();
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         repeat (8) step();
         bus.out_ready = 1'b0;
      end

      // Flush at level 3; errors must survive.
      bus.in_last = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = DW'(8'hA0 + i);
         step();
      end
      bus.in_valid = 1'b0;
      step();
      flush         = 1'b1;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      step();
      flush         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      repeat (2) step();

      run(100, 100, 100, 0);
      run(400, 70, 50, 0);
      run(300, 90, 20, 0);
      run(300, 60, 60, 2);

      bus.out_ready = 1'b1;
      repeat (10) step();
      bus.out_ready = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
